mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder to the control unit's read/write strobes: owns a byte-wide program/data store.
//  IN: host streams program bytes in. CHECK: streams them back for verification.
//  RUN: answers CPU read/write cycles at the address register output.
//  Sits between the host loader port, the AR/DR datapath and the internal bus.
// PARAMETERS
//  ADDR_W   16   CPU address width (AR output)
//  MEM_AW   8    implemented address bits; DEPTH = 2**MEM_AW bytes
// PORTS
//  clk             in   1       system clock, rising edge
//  rst             in   1       asynchronous, active-low reset
//  cpustate        in   2       00 IDLE, 01 IN, 10 CHECK, 11 RUN
//  cpu_addr        in   ADDR_W  address from AR
//  read            in   1       CPU read strobe (with membus)
//  write           in   1       CPU write strobe (with busmem)
//  cpu_wdata       in   8       bus data to store
//  cpu_rdata       out  8       read data to bus, same-cycle
//  addr_err        out  1       1-cycle pulse: RUN access with cpu_addr[ADDR_W-1:MEM_AW]!=0
//  host_din        in   8       load byte
//  host_valid      in   1       load byte valid
//  host_ready      out  1       responder accepts load byte
//  host_dout       out  8       check byte
//  host_dout_valid out  1       check byte valid
//  host_dout_ready in   1       host consumes check byte
//  load_len        out  MEM_AW+1  bytes loaded in last IN session
//  check_done      out  1       CHECK finished (level, until mode change)
//  overflow        out  1       IN session hit DEPTH with host_valid still high (sticky per session)
// BEHAVIOUR
//  Reset: FSM=S_IDLE, ptr=0, load_len=0; all outputs 0. Memory contents NOT reset.
//  FSM: S_IDLE, S_LOAD, S_CHECK, S_CHKDONE, S_RUN. State follows cpustate registered on clk.
//   On any cpustate change: ptr<=0, check_done<=0, any in-flight transfer is abandoned.
//   Exception: leaving S_LOAD copies ptr into load_len.
//   Entering S_LOAD also clears overflow.
//  S_LOAD:
//   - host_ready = (ptr<DEPTH).
//   - host_valid&host_ready at posedge: mem[ptr]<=host_din, ptr<=ptr+1.
//   - ptr==DEPTH: host_ready=0; host_valid sets overflow. No wrap.
//  S_CHECK:
//   - host_dout_valid=1, host_dout=mem[ptr], held stable until host_dout_ready.
//   - valid&ready: ptr+1.
//   - When ptr==load_len: go to S_CHKDONE, valid=0, check_done=1.
//   - load_len==0: S_CHKDONE on the first cycle.
//  S_RUN:
//   - cpu_rdata = read ? mem[cpu_addr[MEM_AW-1:0]] : 0.
//   - write at posedge: mem[addr]<=cpu_wdata.
//   - read&write in the same cycle: write takes effect; cpu_rdata shows the pre-write value.
//   - Out-of-range address: rdata=0, write dropped, addr_err pulses.
//  Outside RUN: read/write ignored, cpu_rdata=0, addr_err=0.
//  Outside LOAD: host_ready=0. Outside CHECK: host_dout_valid=0.
//  Reset asserted mid-session: immediate return to reset values; partial load keeps bytes already written.
// STRUCTURE
//  Shared header cpu_defs.vh:
//   - cpustate encodings CS_IDLE/CS_IN/CS_CHECK/CS_RUN (RUN=2'b11 matches control reset gating).
//   - FSM state localparams.
//  Sub-module mem_array:
//   - DEPTH x 8 register array.
//   - One write port, muxed between host and CPU by state.
//   - One asynchronous read port, muxed between CPU address and ptr.
// TESTING
//  1. Reset, IN, stream 0x11,0x22,0x33 with host_valid held -> 3 accepts, leave IN -> load_len=3.
//  2. CHECK after (1), host_dout_ready toggling 1/0 -> bytes 11,22,33 each held while unready;
//     then check_done=1, valid=0.
//  3. RUN: read@0x0001 -> rdata 0x22.
//     write 0xA5@0x0001 with read high -> rdata 0x22 that cycle, 0xA5 next read.
//  4. IN with DEPTH+2 valid bytes -> host_ready low after DEPTH accepts, overflow=1, load_len=DEPTH.
//  5. RUN read@0x0100 -> rdata 0x00, addr_err 1 cycle; write@0x0100 leaves mem[0x00] unchanged.
//  6. rst low mid-CHECK (ptr=2) -> outputs 0 immediately.
//     After release with cpustate=CHECK: restarts at ptr 0 with load_len=0 -> check_done next cycle.

Source files
------------

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder_pkg
// Purpose : Shared definitions for the memory responder.
//           - cpustate encodings (RUN = 2'b11 matches the control unit's
//             reset gating).
//           - Responder FSM state type.
//           - Helper that maps a cpustate code to the state entered on a
//             mode change.
// Rev     : 1.0  initial release
// ============================================================================
package mem_responder_pkg;

    localparam logic [1:0] CS_IDLE  = 2'b00;
    localparam logic [1:0] CS_IN    = 2'b01;
    localparam logic [1:0] CS_CHECK = 2'b10;
    localparam logic [1:0] CS_RUN   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CHECK   = 3'd2,
        S_CHKDONE = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    // State entered when cpustate switches to the given mode.
    function automatic state_t entry_state(input logic [1:0] cs);
        state_t st;
        case (cs)
            CS_IN:    st = S_LOAD;
            CS_CHECK: st = S_CHECK;
            CS_RUN:   st = S_RUN;
            default:  st = S_IDLE;
        endcase
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder_if
// Purpose : Bundles the mode, CPU bus and host loader signals of the memory
//           responder.
//   slave  modport : responder side (mem_responder)
//   master modport : control unit / host side
//   cpustate, cpu_addr, read, write, cpu_wdata  : mode and CPU cycle
//   cpu_rdata, addr_err                         : CPU read data / range error
//   host_din, host_valid, host_ready            : program byte stream in
//   host_dout, host_dout_valid, host_dout_ready : verification stream out
//   load_len, check_done, overflow              : session status
// Rev     : 1.0  initial release
// ============================================================================
interface mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int MEM_AW = 8
) ();
    logic [1:0]        cpustate;
    logic [ADDR_W-1:0] cpu_addr;
    logic              read;
    logic              write;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              addr_err;
    logic [7:0]        host_din;
    logic              host_valid;
    logic              host_ready;
    logic [7:0]        host_dout;
    logic              host_dout_valid;
    logic              host_dout_ready;
    logic [MEM_AW:0]   load_len;
    logic              check_done;
    logic              overflow;

    modport slave (
        input  cpustate, cpu_addr, read, write, cpu_wdata,
               host_din, host_valid, host_dout_ready,
        output cpu_rdata, addr_err, host_ready, host_dout, host_dout_valid,
               load_len, check_done, overflow
    );

    modport master (
        output cpustate, cpu_addr, read, write, cpu_wdata,
               host_din, host_valid, host_dout_ready,
        input  cpu_rdata, addr_err, host_ready, host_dout, host_dout_valid,
               load_len, check_done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder_mem_array
// Purpose : 2**MEM_AW x 8 register array, one synchronous write port and one
//           asynchronous read port. Contents are deliberately not reset.
//   clk      in  clock
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out read data (combinational)
// Rev     : 1.0  initial release
// ============================================================================
module mem_responder_mem_array #(
    parameter int MEM_AW = 8
) (
    input  wire logic              clk,
    input  wire logic              we_i,
    input  wire logic [MEM_AW-1:0] waddr_i,
    input  wire logic [7:0]        wdata_i,
    input  wire logic [MEM_AW-1:0] raddr_i,
    output logic      [7:0]        rdata_o
);
    localparam int DEPTH = 1 << MEM_AW;

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder
// Purpose : Memory-side responder owning a byte-wide program/data store.
//           IN streams host bytes in, CHECK streams them back, RUN answers
//           CPU read/write cycles at the AR address.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous, active-low reset
//   bus  mem_responder_if.slave (mode, CPU bus, host streams, status)
// Rev     : 1.0  initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int MEM_AW = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_responder_if.slave bus
);
    localparam logic [MEM_AW:0] PTR_DEPTH = {1'b1, {MEM_AW{1'b0}}};
    localparam logic [MEM_AW:0] PTR_ONE   = (MEM_AW+1)'(1);

    state_t            state_q, state_d;
    logic [1:0]        cs_q;
    logic [MEM_AW:0]   ptr_q, ptr_d;
    logic [MEM_AW:0]   load_len_q, load_len_d;
    logic              overflow_q, overflow_d;

    logic              w_mode_chg;
    logic              w_in_range;
    logic              w_host_ready;
    logic              w_dout_valid;
    logic              w_we;
    logic [MEM_AW-1:0] w_waddr;
    logic [7:0]        w_wdata;
    logic [MEM_AW-1:0] w_raddr;
    logic [7:0]        w_mem_rdata;
    logic [7:0]        w_cpu_rdata;
    logic              w_addr_err;

    // cs_q holds the mode the FSM is currently serving; any difference from
    // the live cpustate is a mode change taking effect at the next edge.
    assign w_mode_chg = (bus.cpustate != cs_q);
    assign w_in_range = (bus.cpu_addr[ADDR_W-1:MEM_AW] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cs_q       <= CS_IDLE;
            ptr_q      <= '0;
            load_len_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= bus.cpustate;
            ptr_q      <= ptr_d;
            load_len_q <= load_len_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_len_d   = load_len_q;
        overflow_d   = overflow_q;
        w_host_ready = 1'b0;
        w_dout_valid = 1'b0;
        w_we         = 1'b0;
        w_waddr      = ptr_q[MEM_AW-1:0];
        w_wdata      = bus.host_din;
        w_raddr      = ptr_q[MEM_AW-1:0];
        w_cpu_rdata  = 8'h00;
        w_addr_err   = 1'b0;

        case (state_q)
            S_LOAD: begin
                // No handshake on a mode-change cycle: the transfer is
                // abandoned rather than half-accepted.
                w_host_ready = (ptr_q != PTR_DEPTH) && !w_mode_chg;
                if (bus.host_valid && w_host_ready) begin
                    w_we  = 1'b1;
                    ptr_d = ptr_q + PTR_ONE;
                end
                if ((ptr_q == PTR_DEPTH) && bus.host_valid) begin
                    overflow_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (ptr_q == load_len_q) begin
                    state_d = S_CHKDONE;
                end else begin
                    w_dout_valid = !w_mode_chg;
                    if (w_dout_valid && bus.host_dout_ready) begin
                        ptr_d = ptr_q + PTR_ONE;
                    end
                end
            end
            S_RUN: begin
                w_raddr = bus.cpu_addr[MEM_AW-1:0];
                if (w_in_range) begin
                    // Asynchronous read shows the pre-write value when read
                    // and write coincide.
                    if (bus.read) begin
                        w_cpu_rdata = w_mem_rdata;
                    end
                    if (bus.write) begin
                        w_we    = 1'b1;
                        w_waddr = bus.cpu_addr[MEM_AW-1:0];
                        w_wdata = bus.cpu_wdata;
                    end
                end else begin
                    w_addr_err = bus.read || bus.write;
                end
            end
            default: ;
        endcase

        if (w_mode_chg) begin
            state_d = entry_state(bus.cpustate);
            ptr_d   = '0;
            if (state_q == S_LOAD) begin
                load_len_d = ptr_q;
            end
            if (bus.cpustate == CS_IN) begin
                overflow_d = 1'b0;
            end
        end
    end

    mem_responder_mem_array #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (w_wdata),
        .raddr_i (w_raddr),
        .rdata_o (w_mem_rdata)
    );

    assign bus.cpu_rdata       = w_cpu_rdata;
    assign bus.addr_err        = w_addr_err;
    assign bus.host_ready      = w_host_ready;
    assign bus.host_dout_valid = w_dout_valid;
    assign bus.host_dout       = w_dout_valid ? w_mem_rdata : 8'h00;
    assign bus.load_len        = load_len_q;
    assign bus.check_done      = (state_q == S_CHKDONE);
    assign bus.overflow        = overflow_q;
endmodule
`default_nettype wire
